// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU, LSU and debug writeback,
// with a pending-load scoreboard that drives the IDU RAW-hazard stall signals.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_WIDTH-1:0] alu_rd,
  input  logic [WIDTH-1:0]     alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [REG_WIDTH-1:0] lsu_rd,
  input  logic [WIDTH-1:0]     lsu_data,
  output logic                 lsu_ready,
  input  logic                 dbg_valid,
  input  logic [REG_WIDTH-1:0] dbg_rd,
  input  logic [WIDTH-1:0]     dbg_data,
  output logic                 dbg_ready,
  input  logic                 claim_valid,
  input  logic [REG_WIDTH-1:0] claim_rd,
  input  logic [REG_WIDTH-1:0] chk_rs1,
  input  logic [REG_WIDTH-1:0] chk_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic                 wb_wen,
  output logic [REG_WIDTH-1:0] wb_rd,
  output logic [WIDTH-1:0]     wb_valW
);

  localparam int unsigned NREG = 2 ** REG_WIDTH;

  logic [1:0]           rr_q, rr_d;
  logic [NREG-1:0]      pending_q, pending_d;
  logic                 wen_d;
  logic [REG_WIDTH-1:0] rd_d;
  logic [WIDTH-1:0]     val_d;

  logic [2:0]           valid, grant, xfer;
  logic [REG_WIDTH-1:0] sel_rd;
  logic [WIDTH-1:0]     sel_data;

  assign valid = {dbg_valid, lsu_valid, alu_valid};

  // Search starts at rr_q and wraps mod 3: 0=ALU, 1=LSU, 2=DBG.
  always_comb begin
    grant = '0;
    case (rr_q)
      2'd1: begin
        if (valid[1])      grant[1] = 1'b1;
        else if (valid[2]) grant[2] = 1'b1;
        else if (valid[0]) grant[0] = 1'b1;
      end
      2'd2: begin
        if (valid[2])      grant[2] = 1'b1;
        else if (valid[0]) grant[0] = 1'b1;
        else if (valid[1]) grant[1] = 1'b1;
      end
      default: begin
        if (valid[0])      grant[0] = 1'b1;
        else if (valid[1]) grant[1] = 1'b1;
        else if (valid[2]) grant[2] = 1'b1;
      end
    endcase
  end

  // Readies are masked while reset is asserted so nothing is consumed during reset.
  assign {dbg_ready, lsu_ready, alu_ready} = grant & {3{rst}};
  assign xfer = valid & {dbg_ready, lsu_ready, alu_ready};

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    rr_d     = rr_q;
    if (xfer[1]) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
      rr_d     = 2'd2;
    end else if (xfer[2]) begin
      sel_rd   = dbg_rd;
      sel_data = dbg_data;
      rr_d     = 2'd0;
    end else if (xfer[0]) begin
      rr_d     = 2'd1;
    end
  end

  always_comb begin
    wen_d = 1'b0;
    rd_d  = wb_rd;
    val_d = wb_valW;
    if (|xfer) begin
      wen_d = (sel_rd != '0);
      rd_d  = sel_rd;
      val_d = sel_data;
    end
  end

  // Clear from the LSU first so a same-cycle claim of the same rd wins.
  always_comb begin
    pending_d = pending_q;
    if (xfer[1]) pending_d[lsu_rd] = 1'b0;
    if (claim_valid && (claim_rd != '0)) pending_d[claim_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= 2'd0;
      pending_q <= '0;
      wb_wen    <= 1'b0;
      wb_rd     <= '0;
      wb_valW   <= '0;
    end else begin
      rr_q      <= rr_d;
      pending_q <= pending_d;
      wb_wen    <= wen_d;
      wb_rd     <= rd_d;
      wb_valW   <= val_d;
    end
  end

  // Data still in the output register is not yet visible in the regfile.
  assign busy_rs1 = (chk_rs1 != '0) && (pending_q[chk_rs1] || (wb_wen && (wb_rd == chk_rs1)));
  assign busy_rs2 = (chk_rs2 != '0) && (pending_q[chk_rs2] || (wb_wen && (wb_rd == chk_rs2)));

endmodule
